multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the single-register-file MIPS-subset datapath.
- Steps each instruction through FETCH, DECODE, EXEC and WB.
- Gates the PC, IR and register-file write enables; drives RegDst/ALUSrc/ALUOp from the latched opcode class.
- Holds EXEC for a configurable number of cycles on multiply.
- Sits between instruction memory (ready handshake) and the existing ALU_Control / register-file datapath.

Parameters:
- MUL_CYCLES, 4, cycles spent in EXEC for a multiply (legal range 1..15).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- Op_i  in  6  opcode field of IR; sampled only in DECODE.
- funct_i  in  6  funct field of IR; sampled only in DECODE.
- mem_ready_i  in  1  instruction memory has valid data this cycle.
- stall_i  in  1  external freeze request.
- PCWrite_o  out  1  PC update enable.
- IRWrite_o  out  1  IR load enable.
- RegDst_o  out  1  1 = rd, 0 = rt.
- ALUSrc_o  out  1  1 = immediate, 0 = rt register.
- ALUOp_o  out  2  2'd0 add (immediate class), 2'd3 R-type (funct-decoded).
- RegWrite_o  out  1  register-file write enable.
- mul_busy_o  out  1  multiply in progress.
- illegal_o  out  1  unsupported opcode detected.
- retire_o  out  1  one-cycle pulse when an instruction completes.
- state_o  out  2  current state (debug).
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, WB=3. Reset state is FETCH.
- Reset: on a clock edge with rst_i=1, state becomes FETCH and the class register, mul counter and instr_cnt_o clear. Reset takes effect mid-instruction with no completion.
- While rst_i=1, every 1-bit output and ALUOp_o is forced to 0. state_o and instr_cnt_o show their registered values, which read 0 from the first reset edge on.
- Stall: while stall_i=1, state, counter and class hold. PCWrite_o, IRWrite_o, RegWrite_o and retire_o are forced 0. The other outputs hold their state-decoded values.
- FETCH:
  - PCWrite_o = IRWrite_o = mem_ready_i & ~stall_i.
  - Go to DECODE only when mem_ready_i=1; otherwise wait indefinitely.
- DECODE: classify and latch the class.
  - Op_i==6'b000000 → RTYPE. If additionally funct_i==6'b011000 → MUL.
  - Op_i[5:4]==2'b00 and Op_i[3]==1 → IMM.
  - Anything else → ILLEGAL: illegal_o=1 this cycle, next state FETCH, no write, no retire.
  - Otherwise next state EXEC.
  - For MUL, load the counter with MUL_CYCLES-1 on this transition.
- EXEC and WB output decode:
  - IMM: RegDst_o=0, ALUSrc_o=1, ALUOp_o=2'd0.
  - RTYPE and MUL: RegDst_o=1, ALUSrc_o=0, ALUOp_o=2'd3.
  - FETCH and DECODE: these three outputs are 0.
- EXEC:
  - Non-MUL: one cycle, then WB.
  - MUL: mul_busy_o=1 for the whole EXEC stay. The counter decrements each unstalled cycle; go to WB when the counter is 0.
  - EXEC therefore lasts exactly MUL_CYCLES unstalled cycles.
- WB:
  - RegWrite_o=1 and retire_o=1 for one cycle.
  - instr_cnt_o increments modulo 2^CNT_W (wraps from all-ones to 0).
  - Next state FETCH.
- Latency with mem_ready_i constantly 1:
  - Non-MUL instruction: 4 cycles.
  - MUL: 3 + MUL_CYCLES cycles.
  - ILLEGAL: 2 cycles.
- Simultaneous events:
  - rst_i dominates stall_i, and stall_i dominates all transitions.
  - mem_ready_i outside FETCH is ignored.

Decomposition:
- Shared package, used by this block and the bench:
  - State encodings.
  - Opcode constants OP_RTYPE=6'b000000 and FUNCT_MULT=6'b011000.
  - ALUOp encodings ALUOP_ADD=2'd0 and ALUOP_RTYPE=2'd3.
  - Class enum: RTYPE, MUL, IMM, ILLEGAL.
- Sub-module: mul_cycle_counter, a loadable down-counter with a zero flag and hold input. The FSM and output decode stay in the top module.

Test Plan:
- Reset: assert rst_i for 2 cycles with mem_ready_i=1 → all 1-bit outputs and ALUOp_o read 0 while rst_i is high; state_o and instr_cnt_o read 0 from the first reset edge. On release: FETCH, with PCWrite_o=IRWrite_o=1 in that cycle.
- addi: Op_i=6'b001000, mem_ready_i=1 → state sequence 0,1,2,3. In EXEC and WB: ALUSrc_o=1, RegDst_o=0, ALUOp_o=0. RegWrite_o=retire_o=1 only in the 4th cycle; instr_cnt_o goes 0→1.
- R-type add: Op_i=0, funct_i=6'b100000 → ALUOp_o=3, RegDst_o=1, ALUSrc_o=0; 4-cycle retire.
- Multiply, MUL_CYCLES=4: Op_i=0, funct_i=6'b011000 → mul_busy_o high for exactly 4 cycles, retire at cycle 7. Assert stall_i for 2 cycles mid-EXEC → retire at cycle 9, and RegWrite_o=0 during the stall.
- Illegal and memory wait:
  - Op_i=6'b100011 → illegal_o=1 in DECODE, back to FETCH, instr_cnt_o unchanged.
  - mem_ready_i low for 3 cycles in FETCH → remains in FETCH with PCWrite_o=0.
- Wrap and mid-instruction reset:
  - CNT_W=4, retire 16 instructions → instr_cnt_o returns to 0.
  - rst_i asserted during EXEC of a MUL → no RegWrite_o or retire_o; state 0 next cycle.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, opcode classes,
// opcode/funct constants and the DECODE-stage classifier.
package multicycle_control_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CLS_RTYPE   = 2'd0,
      CLS_MUL     = 2'd1,
      CLS_IMM     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } class_e;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_RTYPE = 2'd3;

   // Wide enough for the full legal MUL_CYCLES range (1..15).
   localparam int unsigned MUL_CNT_W = 4;

   function automatic class_e classify(input logic [5:0] op, input logic [5:0] funct);
      class_e cls;
      if (op == OP_RTYPE) begin
         if (funct == FUNCT_MULT) cls = CLS_MUL;
         else                     cls = CLS_RTYPE;
      end else if (op[5:4] == 2'b00 && op[3]) begin
         cls = CLS_IMM;
      end else begin
         cls = CLS_ILLEGAL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/mul_cycle_counter.sv
// Loadable down-counter that times the multiply stay in EXEC; saturates at
// zero and freezes completely while hold_i is high.
module mul_cycle_counter
   import multicycle_control_pkg::*;
#(
   parameter int unsigned W = MUL_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   input  logic         hold_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (!hold_i) begin
         if (load_i)                      cnt_d = load_val_i;
         else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: gates PC/IR/register-file writes
// and drives RegDst/ALUSrc/ALUOp from the opcode class latched in DECODE.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       Op_i,
   input  logic [5:0]       funct_i,
   input  logic             mem_ready_i,
   input  logic             stall_i,
   output logic             PCWrite_o,
   output logic             IRWrite_o,
   output logic             RegDst_o,
   output logic             ALUSrc_o,
   output logic [1:0]       ALUOp_o,
   output logic             RegWrite_o,
   output logic             mul_busy_o,
   output logic             illegal_o,
   output logic             retire_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

   state_e           state_q, state_d;
   class_e           cls_q, cls_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   class_e           dec_cls;
   logic             mul_load, mul_dec, mul_zero;

   assign dec_cls = classify(Op_i, funct_i);

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      instr_cnt_d = instr_cnt_q;
      mul_load    = 1'b0;
      mul_dec     = 1'b0;
      if (!stall_i) begin
         case (state_q)
            ST_FETCH: if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
               cls_d = dec_cls;
               if (dec_cls == CLS_ILLEGAL) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d  = ST_EXEC;
                  mul_load = (dec_cls == CLS_MUL);
               end
            end
            ST_EXEC: begin
               if (cls_q != CLS_MUL || mul_zero) state_d = ST_WB;
               else                              mul_dec = 1'b1;
            end
            ST_WB: begin
               instr_cnt_d = instr_cnt_q + CNT_W'(1);
               state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_FETCH;
         cls_q       <= CLS_RTYPE;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   mul_cycle_counter #(.W(MUL_CNT_W)) u_mul_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (mul_load),
      .load_val_i (MUL_LOAD),
      .dec_i      (mul_dec),
      .hold_i     (stall_i),
      .zero_o     (mul_zero)
   );

   // Reset forces every control strobe low; stall only masks the write/retire strobes.
   always_comb begin
      PCWrite_o  = 1'b0;
      IRWrite_o  = 1'b0;
      RegDst_o   = 1'b0;
      ALUSrc_o   = 1'b0;
      ALUOp_o    = ALUOP_ADD;
      RegWrite_o = 1'b0;
      mul_busy_o = 1'b0;
      illegal_o  = 1'b0;
      retire_o   = 1'b0;
      if (!rst_i) begin
         if (state_q == ST_FETCH) begin
            PCWrite_o = mem_ready_i & ~stall_i;
            IRWrite_o = mem_ready_i & ~stall_i;
         end
         if (state_q == ST_DECODE) illegal_o = (dec_cls == CLS_ILLEGAL);
         if (state_q == ST_EXEC || state_q == ST_WB) begin
            if (cls_q == CLS_IMM) begin
               ALUSrc_o = 1'b1;
               ALUOp_o  = ALUOP_ADD;
            end else begin
               RegDst_o = 1'b1;
               ALUOp_o  = ALUOP_RTYPE;
            end
         end
         mul_busy_o = (state_q == ST_EXEC) && (cls_q == CLS_MUL);
         if (state_q == ST_WB) begin
            RegWrite_o = ~stall_i;
            retire_o   = ~stall_i;
         end
      end
   end

   assign state_o     = state_q;
   assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-phase model checked
// every cycle, plus hand-computed latency/decode expectations.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   localparam int MULC = 4;
   localparam int CW   = 4;

   logic          clk_i = 1'b0;
   logic          rst_i, mem_ready_i, stall_i;
   logic [5:0]    Op_i, funct_i;
   logic          PCWrite_o, IRWrite_o, RegDst_o, ALUSrc_o, RegWrite_o;
   logic          mul_busy_o, illegal_o, retire_o;
   logic [1:0]    ALUOp_o, state_o;
   logic [CW-1:0] instr_cnt_o;

   always #5 clk_i = ~clk_i;

   multicycle_control #(.MUL_CYCLES(MULC), .CNT_W(CW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .Op_i        (Op_i),
      .funct_i     (funct_i),
      .mem_ready_i (mem_ready_i),
      .stall_i     (stall_i),
      .PCWrite_o   (PCWrite_o),
      .IRWrite_o   (IRWrite_o),
      .RegDst_o    (RegDst_o),
      .ALUSrc_o    (ALUSrc_o),
      .ALUOp_o     (ALUOp_o),
      .RegWrite_o  (RegWrite_o),
      .mul_busy_o  (mul_busy_o),
      .illegal_o   (illegal_o),
      .retire_o    (retire_o),
      .state_o     (state_o),
      .instr_cnt_o (instr_cnt_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction model: phase 0 = fetch, 1 = decode, then a run of execute
   // cycles whose last cycle is write-back; m_len is the instruction's length.
   int     m_phase = 0;
   int     m_len   = 4;
   int     m_cnt   = 0;
   class_e m_cls   = CLS_RTYPE;
   bit     m_valid = 1'b0;

   function automatic class_e ref_class(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'd0) return (fn == 6'd24) ? CLS_MUL : CLS_RTYPE;
      if (op >= 6'd8 && op <= 6'd15) return CLS_IMM;
      return CLS_ILLEGAL;
   endfunction

   always @(posedge clk_i) begin
      if (rst_i) begin
         m_phase = 0;
         m_cnt   = 0;
         m_valid = 1'b1;
      end else if (!stall_i) begin
         if (m_phase == 0) begin
            if (mem_ready_i) m_phase = 1;
         end else if (m_phase == 1) begin
            m_cls = ref_class(Op_i, funct_i);
            if (m_cls == CLS_ILLEGAL) m_phase = 0;
            else begin
               m_len   = (m_cls == CLS_MUL) ? 3 + MULC : 4;
               m_phase = 2;
            end
         end else if (m_phase == m_len - 1) begin
            m_cnt   = (m_cnt + 1) % (1 << CW);
            m_phase = 0;
         end else begin
            m_phase++;
         end
      end
   end

   always @(negedge clk_i) begin : compare
      logic [9:0] e;
      int st;
      if (m_valid) begin
         e = '0;
         if (m_phase == 0)                st = 0;
         else if (m_phase == 1)           st = 1;
         else if (m_phase == m_len - 1)   st = 3;
         else                             st = 2;
         if (!rst_i) begin
            if (st == 0) begin
               e[9] = mem_ready_i & ~stall_i;
               e[8] = mem_ready_i & ~stall_i;
            end else if (st == 1) begin
               e[1] = (ref_class(Op_i, funct_i) == CLS_ILLEGAL);
            end else begin
               if (m_cls == CLS_IMM) begin
                  e[6] = 1'b1;
                  e[5:4] = ALUOP_ADD;
               end else begin
                  e[7] = 1'b1;
                  e[5:4] = ALUOP_RTYPE;
               end
               if (st == 2 && m_cls == CLS_MUL) e[2] = 1'b1;
               if (st == 3 && !stall_i) begin
                  e[3] = 1'b1;
                  e[0] = 1'b1;
               end
            end
         end
         check("cycle_outputs", 32'({PCWrite_o, IRWrite_o, RegDst_o, ALUSrc_o, ALUOp_o,
                                     RegWrite_o, mul_busy_o, illegal_o, retire_o}), 32'(e));
         check("cycle_state", 32'(state_o), 32'(st));
         check("cycle_instr_cnt", 32'(instr_cnt_o), 32'(m_cnt));
      end
   end

   // Runs one instruction from FETCH; stall_i is high on cycles [st_from, st_from+st_len).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int st_from, input int st_len,
                            output int lat, output int busy, output int wr,
                            output logic [3:0] dec3, output logic [1:0] pcw1);
      int cyc  = 0;
      bit done = 1'b0;
      Op_i = op;
      funct_i = fn;
      mem_ready_i = 1'b1;
      lat = 0; busy = 0; wr = 0; dec3 = '0; pcw1 = '0;
      while (!done && cyc < 40) begin
         cyc++;
         stall_i = (cyc >= st_from && cyc < st_from + st_len);
         @(negedge clk_i);
         if (mul_busy_o) busy++;
         if (RegWrite_o) wr++;
         if (cyc == 1) pcw1 = {PCWrite_o, IRWrite_o};
         if (cyc == 3) dec3 = {RegDst_o, ALUSrc_o, ALUOp_o};
         if (retire_o || illegal_o) begin
            done = 1'b1;
            lat  = cyc;
         end
         @(posedge clk_i);
         #1;
      end
      stall_i = 1'b0;
      check("instr_completed", 32'(done), 32'd1);
   endtask

   int         lat, busy, wr;
   logic [3:0] dec3;
   logic [1:0] pcw1;

   initial begin
      rst_i = 1'b1; mem_ready_i = 1'b1; stall_i = 1'b0; Op_i = '0; funct_i = '0;

      // Reset: strobes low while rst_i is high, registers read 0 after first edge.
      @(negedge clk_i);
      check("rst_pcwrite_low", 32'(PCWrite_o), 32'd0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_cnt", 32'(instr_cnt_o), 32'd0);
      check("rst_strobes", 32'({PCWrite_o, IRWrite_o, RegWrite_o, retire_o, ALUOp_o}), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // addi
      run_instr(6'b001000, 6'd0, 0, 0, lat, busy, wr, dec3, pcw1);
      check("rel_pcw_irw", 32'(pcw1), 32'b11);
      check("addi_lat", 32'(lat), 32'd4);
      check("addi_decode", 32'(dec3), 32'b0100);
      check("addi_wr", 32'(wr), 32'd1);
      check("addi_cnt", 32'(instr_cnt_o), 32'd1);

      // R-type add
      run_instr(6'd0, 6'b100000, 0, 0, lat, busy, wr, dec3, pcw1);
      check("radd_lat", 32'(lat), 32'd4);
      check("radd_decode", 32'(dec3), 32'b1011);

      // multiply, unstalled then stalled for 2 cycles mid-EXEC
      run_instr(6'd0, 6'b011000, 0, 0, lat, busy, wr, dec3, pcw1);
      check("mul_lat", 32'(lat), 32'd7);
      check("mul_busy", 32'(busy), 32'd4);
      run_instr(6'd0, 6'b011000, 4, 2, lat, busy, wr, dec3, pcw1);
      check("mul_stall_lat", 32'(lat), 32'd9);
      check("mul_stall_busy", 32'(busy), 32'd6);
      check("mul_stall_wr", 32'(wr), 32'd1);
      check("mul_cnt", 32'(instr_cnt_o), 32'd4);

      // illegal opcode: two cycles, no retire
      run_instr(6'b100011, 6'd0, 0, 0, lat, busy, wr, dec3, pcw1);
      check("ill_lat", 32'(lat), 32'd2);
      check("ill_wr", 32'(wr), 32'd0);
      check("ill_cnt", 32'(instr_cnt_o), 32'd4);

      // instruction memory not ready for 3 cycles
      mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("wait_state", 32'(state_o), 32'd0);
         check("wait_pcwrite", 32'(PCWrite_o), 32'd0);
         @(posedge clk_i); #1;
      end
      run_instr(6'b001100, 6'd0, 0, 0, lat, busy, wr, dec3, pcw1);
      check("wait_addi_lat", 32'(lat), 32'd4);

      // stall in FETCH and in WB
      run_instr(6'd0, 6'b100010, 1, 1, lat, busy, wr, dec3, pcw1);
      check("fetch_stall_lat", 32'(lat), 32'd5);
      run_instr(6'b001000, 6'd0, 4, 1, lat, busy, wr, dec3, pcw1);
      check("wb_stall_lat", 32'(lat), 32'd5);
      check("wb_stall_wr", 32'(wr), 32'd1);
      check("stall_cnt", 32'(instr_cnt_o), 32'd7);

      // counter wrap after 16 retirements from reset
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         run_instr(6'b001000, 6'd0, 0, 0, lat, busy, wr, dec3, pcw1);
         if (i == 14) check("cnt_15", 32'(instr_cnt_o), 32'd15);
      end
      check("cnt_wrap", 32'(instr_cnt_o), 32'd0);

      // reset during multiply EXEC: no write, no retire, back to FETCH
      Op_i = 6'd0; funct_i = 6'b011000; mem_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i); #1;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_state_exec", 32'(state_o), 32'd2);
      check("midrst_no_write", 32'({RegWrite_o, retire_o, mul_busy_o}), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_fetch", 32'(state_o), 32'd0);
      check("midrst_cnt", 32'(instr_cnt_o), 32'd0);
      @(posedge clk_i); #1;
      // FETCH consumed one cycle above with mem_ready high; finish the mul from DECODE.
      run_instr(6'd0, 6'b011000, 0, 0, lat, busy, wr, dec3, pcw1);
      check("post_rst_mul_lat", 32'(lat), 32'd6);
      check("post_rst_cnt", 32'(instr_cnt_o), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
